// File: rtl/adc_sample_ctrl_if.sv
// rtl/adc_sample_ctrl_if.sv - ADC framing, trigger and sample-handshake signal bundle
interface adc_sample_ctrl_if;
    logic        En;
    logic        Start;
    logic        SCLK;
    logic        CSn;
    logic [11:0] DATAIN;
    logic [11:0] SAMPLE;
    logic        VALID;
    logic        READY;
    logic        OVERRUN;
    logic        BUSY;

    modport master (
        input  En,
        input  Start,
        input  DATAIN,
        input  READY,
        output SCLK,
        output CSn,
        output SAMPLE,
        output VALID,
        output OVERRUN,
        output BUSY
    );

    modport slave (
        output En,
        output Start,
        output DATAIN,
        output READY,
        input  SCLK,
        input  CSn,
        input  SAMPLE,
        input  VALID,
        input  OVERRUN,
        input  BUSY
    );
endinterface

// File: rtl/adc_sample_ctrl.sv
// rtl/adc_sample_ctrl.sv - PmodAD1 conversion scheduler with valid/ready sample output
// Optional feature: ADC_AVG_EN (4-capture averaging before the handshake).
module adc_sample_ctrl #(
    parameter int SCLK_DIV      = 4,
    parameter int FRAME_BITS    = 16,
    parameter int DES_LAT       = 2,
    parameter int QUIET_CYCLES  = 8,
    parameter int SAMPLE_PERIOD = 250
) (
    input  logic                 Clk,
    input  logic                 Rst,
    adc_sample_ctrl_if.master    bus
);

    localparam logic [15:0] DIV_LAST    = 16'(SCLK_DIV - 1);
    localparam logic [15:0] TOG_LAST    = 16'(2 * FRAME_BITS - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(DES_LAT - 1);
    localparam logic [15:0] QUIET_LAST  = 16'(QUIET_CYCLES - 1);
    localparam logic [15:0] PER_LAST    = 16'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONVERT = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        QUIET   = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] per_cnt;
    logic [15:0] div_cnt;
    logic [15:0] tog_cnt;
    logic [15:0] wait_cnt;
    logic        csn_q;
    logic        sclk_q;
    logic        busy_q;
    logic [11:0] sample_q;
    logic        valid_q;
    logic        overrun_q;

    logic        tick;
    logic        trigger;
    logic        xfer;
    logic        cap_load;
    logic [11:0] cap_value;

    assign tick    = bus.En && (per_cnt == PER_LAST);
    assign trigger = tick || bus.Start;
    assign xfer    = valid_q && bus.READY;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            per_cnt <= '0;
        end else if (!bus.En || per_cnt == PER_LAST) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 16'd1;
        end
    end

    // CSn, SCLK and BUSY are updated alongside the state so all three stay registered.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state    <= IDLE;
            csn_q    <= 1'b1;
            sclk_q   <= 1'b1;
            busy_q   <= 1'b0;
            div_cnt  <= '0;
            tog_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state   <= CONVERT;
                        csn_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        div_cnt <= '0;
                        tog_cnt <= '0;
                    end
                end
                CONVERT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        tog_cnt <= tog_cnt + 16'd1;
                        if (tog_cnt == TOG_LAST) begin
                            // Final rising edge coincides with CSn release.
                            state    <= SETTLE;
                            csn_q    <= 1'b1;
                            sclk_q   <= 1'b1;
                            wait_cnt <= '0;
                        end else begin
                            sclk_q <= ~sclk_q;
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                SETTLE: begin
                    if (wait_cnt == SETTLE_LAST) begin
                        state    <= CAPTURE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                CAPTURE: begin
                    state    <= QUIET;
                    wait_cnt <= '0;
                end
                QUIET: begin
                    if (wait_cnt == QUIET_LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    csn_q  <= 1'b1;
                    sclk_q <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ADC_AVG_EN
    logic [13:0] acc;
    logic [1:0]  cap_cnt;
    logic [13:0] acc_sum;

    assign acc_sum   = acc + {2'b00, bus.DATAIN};
    assign cap_load  = (state == CAPTURE) && (cap_cnt == 2'd3);
    assign cap_value = acc_sum[13:2];

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            acc     <= '0;
            cap_cnt <= '0;
        end else if (state == CAPTURE) begin
            if (cap_cnt == 2'd3) begin
                acc     <= '0;
                cap_cnt <= '0;
            end else begin
                acc     <= acc_sum;
                cap_cnt <= cap_cnt + 2'd1;
            end
        end
    end
`else
    assign cap_load  = (state == CAPTURE);
    assign cap_value = bus.DATAIN;
`endif

    // A capture landing on a transfer edge both hands off the old sample and keeps VALID high.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (cap_load) begin
                sample_q <= cap_value;
                valid_q  <= 1'b1;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end

            if (cap_load && valid_q && !bus.READY) begin
                overrun_q <= 1'b1;
            end else if (xfer) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.CSn     = csn_q;
    assign bus.SCLK    = sclk_q;
    assign bus.BUSY    = busy_q;
    assign bus.SAMPLE  = sample_q;
    assign bus.VALID   = valid_q;
    assign bus.OVERRUN = overrun_q;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// tb/tb_adc_sample_ctrl.sv - directed table-driven bench for adc_sample_ctrl
module tb_adc_sample_ctrl;

    logic clk;
    logic rst;

    adc_sample_ctrl_if bus ();

    adc_sample_ctrl dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] datain;
        logic        ready;
        logic [11:0] exp_sample;
        logic        exp_valid;
        logic        exp_overrun;
    } vec_t;

    vec_t vecs[$];

    int n_vec;
    int n_fail;
    int lows;
    int falls;
    int sclk_bad;
    int valid_cnt;
    int got;
    int last_view;
    logic prev_sclk;
    logic v132, v131, b139, b140, csn1, csn129;
    logic [11:0] s132;
    logic [11:0] per_exp [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic pulse_start();
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        rst = 1'b0;
        bus.En = 1'b0;
        bus.Start = 1'b0;
        bus.READY = 1'b0;
        bus.DATAIN = 12'h000;

`ifdef ADC_AVG_EN
        vecs.push_back('{12'h100, 1'b0, 12'h000, 1'b0, 1'b0});
        vecs.push_back('{12'h200, 1'b0, 12'h000, 1'b0, 1'b0});
        vecs.push_back('{12'h300, 1'b0, 12'h000, 1'b0, 1'b0});
        vecs.push_back('{12'h401, 1'b0, 12'h280, 1'b1, 1'b0});
`else
        vecs.push_back('{12'hC93, 1'b0, 12'hC93, 1'b1, 1'b0});
        vecs.push_back('{12'h5A5, 1'b0, 12'h5A5, 1'b1, 1'b1});
        vecs.push_back('{12'h000, 1'b1, 12'h000, 1'b0, 1'b0});
        vecs.push_back('{12'hFFF, 1'b0, 12'hFFF, 1'b1, 1'b0});
        vecs.push_back('{12'h7FF, 1'b0, 12'h7FF, 1'b1, 1'b1});
        vecs.push_back('{12'h001, 1'b1, 12'h001, 1'b0, 1'b0});
`endif

        do_reset();
        chk("reset_csn", bus.CSn, 1'b1);
        chk("reset_sclk", bus.SCLK, 1'b1);
        chk("reset_sample", bus.SAMPLE, 12'h000);
        chk("reset_valid", bus.VALID, 1'b0);
        chk("reset_overrun", bus.OVERRUN, 1'b0);
        chk("reset_busy", bus.BUSY, 1'b0);

        // Each vector is one on-demand frame; outputs are checked once the controller is idle again.
        foreach (vecs[i]) begin
            bus.DATAIN = vecs[i].datain;
            bus.READY  = vecs[i].ready;
            pulse_start();
            repeat (139) step();
            chk($sformatf("vec%0d_sample", i), bus.SAMPLE, vecs[i].exp_sample);
            chk($sformatf("vec%0d_valid", i), bus.VALID, vecs[i].exp_valid);
            chk($sformatf("vec%0d_overrun", i), bus.OVERRUN, vecs[i].exp_overrun);
            chk($sformatf("vec%0d_busy", i), bus.BUSY, 1'b0);
        end
        bus.READY = 1'b0;

`ifndef ADC_AVG_EN
        // Single shot: frame framing and latency, view i is the state just after edge T+i-1.
        do_reset();
        bus.DATAIN = 12'hC93;
        pulse_start();
        lows = 0; falls = 0; sclk_bad = 0; prev_sclk = 1'b1;
        for (int i = 1; i <= 140; i++) begin
            if (!bus.CSn) lows++;
            if (prev_sclk && !bus.SCLK) falls++;
            if (bus.CSn && !bus.SCLK) sclk_bad++;
            prev_sclk = bus.SCLK;
            if (i == 1)   csn1   = bus.CSn;
            if (i == 129) csn129 = bus.CSn;
            if (i == 131) v131   = bus.VALID;
            if (i == 132) begin v132 = bus.VALID; s132 = bus.SAMPLE; end
            if (i == 139) b139   = bus.BUSY;
            if (i == 140) b140   = bus.BUSY;
            step();
        end
        chk("shot_csn_first", csn1, 1'b0);
        chk("shot_csn_release", csn129, 1'b1);
        chk("shot_csn_low_cycles", lows, 128);
        chk("shot_sclk_falls", falls, 16);
        chk("shot_sclk_idle_high", sclk_bad, 0);
        chk("shot_valid_early", v131, 1'b0);
        chk("shot_valid_on_time", v132, 1'b1);
        chk("shot_sample", s132, 12'hC93);
        chk("shot_busy_quiet", b139, 1'b1);
        chk("shot_busy_done", b140, 1'b0);

        // Periodic: three frames, 250 cycles apart, drained immediately.
        do_reset();
        per_exp[0] = 12'h895; per_exp[1] = 12'h589; per_exp[2] = 12'hAAA;
        bus.READY = 1'b1;
        bus.DATAIN = per_exp[0];
        bus.En = 1'b1;
        got = 0; last_view = 0; valid_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (bus.OVERRUN) valid_cnt++;
            if (bus.VALID) begin
                if (got < 3) chk($sformatf("per%0d_sample", got), bus.SAMPLE, per_exp[got]);
                if (got > 0 && got < 3) chk($sformatf("per%0d_interval", got), i - last_view, 250);
                last_view = i;
                got++;
                if (got < 3) bus.DATAIN = per_exp[got];
            end
            step();
        end
        chk("per_count", got, 3);
        chk("per_overrun_views", valid_cnt, 0);
        bus.En = 1'b0;
        bus.READY = 1'b0;

        // Overrun across two periodic frames, then a single-cycle drain.
        do_reset();
        bus.DATAIN = 12'h123;
        bus.En = 1'b1;
        got = 0;
        while (!bus.VALID && got < 400) begin step(); got++; end
        chk("ovr_first_timeout", got < 400, 1'b1);
        bus.DATAIN = 12'h456;
        got = 0;
        while (bus.SAMPLE != 12'h456 && got < 300) begin step(); got++; end
        bus.En = 1'b0;
        chk("ovr_sample", bus.SAMPLE, 12'h456);
        chk("ovr_valid", bus.VALID, 1'b1);
        chk("ovr_flag", bus.OVERRUN, 1'b1);
        bus.READY = 1'b1;
        step();
        bus.READY = 1'b0;
        chk("ovr_drain_valid", bus.VALID, 1'b0);
        chk("ovr_drain_flag", bus.OVERRUN, 1'b0);

        // Simultaneous transfer and capture.
        do_reset();
        bus.DATAIN = 12'h3C3;
        pulse_start();
        repeat (139) step();
        bus.DATAIN = 12'hA5A;
        pulse_start();
        repeat (130) step();
        chk("sim_old_sample", bus.SAMPLE, 12'h3C3);
        chk("sim_old_valid", bus.VALID, 1'b1);
        bus.READY = 1'b1;
        step();
        bus.READY = 1'b0;
        chk("sim_new_sample", bus.SAMPLE, 12'hA5A);
        chk("sim_valid_held", bus.VALID, 1'b1);
        chk("sim_overrun", bus.OVERRUN, 1'b0);

        // Start pulsed mid-frame is dropped.
        do_reset();
        bus.DATAIN = 12'h0F0;
        pulse_start();
        lows = 0;
        for (int i = 1; i <= 300; i++) begin
            bus.Start = (i == 20);
            if (!bus.CSn) lows++;
            step();
        end
        bus.Start = 1'b0;
        chk("drop_csn_low_cycles", lows, 128);
        chk("drop_sample", bus.SAMPLE, 12'h0F0);

        // Reset mid-CONVERT abandons the frame.
        do_reset();
        bus.DATAIN = 12'h777;
        pulse_start();
        repeat (50) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rst_mid_csn", bus.CSn, 1'b1);
        chk("rst_mid_sclk", bus.SCLK, 1'b1);
        chk("rst_mid_valid", bus.VALID, 1'b0);
        chk("rst_mid_busy", bus.BUSY, 1'b0);
        valid_cnt = 0; lows = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.VALID) valid_cnt++;
            if (!bus.CSn) lows++;
            step();
        end
        chk("rst_mid_no_sample", valid_cnt, 0);
        chk("rst_mid_no_frame", lows, 0);
        chk("rst_mid_sample_zero", bus.SAMPLE, 12'h000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_ctrl.md
# adc_sample_ctrl

Conversion scheduler for the PmodAD1 capture path. It generates CSn and SCLK framing for the ADC and its Deserializer, either periodically or on demand. It captures the Deserializer's 12-bit DATAOUT after each frame and presents it downstream through a valid/ready handshake with overrun detection. It sits between the Deserializer and the DSP/DAC side of the design.

## Interface
- SCLK_DIV, 4: SCLK half-period in Clk cycles (SCLK = Clk / (2*SCLK_DIV)); ≥1.
- FRAME_BITS, 16: SCLK falling edges per frame (4 leading zeros + 12 data bits).
- DES_LAT, 2: Clk cycles from CSn rising until Deserializer DATAOUT is valid.
- QUIET_CYCLES, 8: minimum CSn-high time after a capture, in Clk cycles.
- SAMPLE_PERIOD, 250: periodic trigger interval in Clk cycles; ≥2.
- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  synchronous, active-low reset.
- En  in  1  enables the periodic trigger counter.
- Start  in  1  one-cycle manual conversion request.
- SCLK  out  1  ADC serial clock; idles high.
- CSn  out  1  ADC chip select; idles high.
- DATAIN  in  12  Deserializer DATAOUT.
- SAMPLE  out  12  captured sample.
- VALID  out  1  SAMPLE holds an unconsumed value.
- READY  in  1  downstream accepts SAMPLE when VALID && READY.
- OVERRUN  out  1  sticky; an unconsumed sample was overwritten.
- BUSY  out  1  state ≠ IDLE.

## Operation
- Reset (Rst=0 at a Clk edge) forces: state IDLE, CSn=1, SCLK=1, SAMPLE=0, VALID=0, OVERRUN=0, BUSY=0, all counters 0. Reset mid-frame abandons the frame; no sample is produced.
- Period counter runs 0..SAMPLE_PERIOD-1 while En=1 and wraps. The tick fires at value SAMPLE_PERIOD-1. The counter holds at 0 while En=0.
- Trigger = tick || Start. A trigger accepted in IDLE starts a frame. A trigger in any other state is dropped; it is not queued and not flagged.
- States:
  - IDLE -> CONVERT on trigger.
  - CONVERT: CSn=0. SCLK toggles every SCLK_DIV cycles, starting with a falling edge SCLK_DIV cycles after CSn falls. After FRAME_BITS falling edges and the final rising edge -> SETTLE with CSn=1.
  - SETTLE: wait DES_LAT cycles -> CAPTURE.
  - CAPTURE: one cycle; loads SAMPLE <= DATAIN -> QUIET.
  - QUIET: QUIET_CYCLES cycles -> IDLE.
- Handshake:
  - VALID rises the cycle after CAPTURE.
  - VALID stays 1, with SAMPLE stable, until VALID && READY at an edge. VALID then falls unless a capture lands in the same cycle.
  - Capture with VALID=1 and READY=0: SAMPLE is overwritten, VALID stays 1, OVERRUN is set.
  - Capture with VALID=1 and READY=1 in the same cycle: the old sample is transferred, the new one is loaded, VALID stays 1, no overrun.
  - OVERRUN clears on the first completed transfer after it was set, and on reset.

## Timing
- CSn low duration = 2*SCLK_DIV*FRAME_BITS cycles; 128 with the defaults.
- Trigger sampled at edge T -> CSn=0 from T+1. VALID=1 from T+1+128+DES_LAT+1 = T+132 with defaults.
- Minimum frame-to-frame spacing = 2*SCLK_DIV*FRAME_BITS + DES_LAT + 1 + QUIET_CYCLES + 1 = 140 with defaults.
- With SAMPLE_PERIOD below this, the ticks that fall inside a frame are dropped.
- SCLK and CSn are registered outputs, glitch-free. SCLK=1 whenever CSn=1.

## Configuration
- ADC_AVG_EN defined: each capture is added into a 14-bit accumulator.
  - Every 4th capture, SAMPLE <= accumulator[13:2] (truncated mean), the accumulator clears, and only that capture affects VALID and OVERRUN.
  - The capture counter and accumulator reset to 0.
- ADC_AVG_EN undefined: every capture drives SAMPLE directly, and no accumulator logic is synthesized.

## Test plan
- Single shot: defaults, En=0, DATAIN=12'hC93, Start pulse at cycle 10 -> CSn low for cycles 11..138. Exactly 16 SCLK falling edges, SCLK high outside the frame. VALID=1 at cycle 142 with SAMPLE=12'hC93, BUSY=0 after QUIET.
- Periodic: En=1, READY=1, DATAIN cycling 12'h895, 12'h589, 12'hAAA -> one VALID pulse per 250 cycles carrying each value in order. OVERRUN stays 0.
- Overrun: En=1, READY=0 across two frames -> SAMPLE shows the second value, OVERRUN=1. Raising READY for one cycle -> VALID=0 and OVERRUN=0 on the next cycle.
- Simultaneous: READY asserted exactly in the capture cycle while VALID=1 -> old value transferred, new value present, VALID stays 1, OVERRUN=0.
- Dropped trigger / reset: Start pulsed during CONVERT -> no second frame. Rst=0 for 1 cycle mid-CONVERT -> next edge CSn=1, SCLK=1, VALID=0, state IDLE, no sample emitted.
- ADC_AVG_EN: DATAIN = 12'h100, 12'h200, 12'h300, 12'h401 over 4 frames -> single VALID with SAMPLE=12'h280.
